// File: rtl/lunar_pkg.sv
// lunar_pkg: shared definitions for the lunar lander autopilot.
// Holds the phase encoding, the default datapath widths and the game constants
// (initial lander state, gravity, phase thresholds and target velocities).
package lunar_pkg;

    typedef enum logic [2:0] {
        PhIdle  = 3'd0,
        PhCoast = 3'd1,
        PhBrake = 3'd2,
        PhFinal = 3'd3,
        PhDone  = 3'd4
    } phase_e;

    // Default widths
    localparam int unsigned NbitsAlt  = 12;
    localparam int unsigned NbitsVelo = 12;
    localparam int unsigned NbitsComb = 8;
    localparam int unsigned NbitsBurn = 7;

    // Initial lander state and physics
    localparam int unsigned FuelInit = 120;
    localparam int          VeloInit = -50;
    localparam int unsigned AltInit  = 500;
    localparam int          Gravity  = 5;

    // Phase thresholds and velocity targets
    localparam int unsigned AltBrake   = 256;
    localparam int unsigned AltFinal   = 64;
    localparam int unsigned VTgtCap    = 40;
    localparam int          VeloBrake  = -40;
    localparam int          VeloSafe   = -10;
    localparam int          VeloFinal  = -2;
    localparam int          BurnMax    = 127;

    function automatic logic is_active(phase_e ph);
        return (ph == PhCoast) || (ph == PhBrake) || (ph == PhFinal);
    endfunction

endpackage

// File: rtl/lunar_burn_law.sv
// lunar_burn_law: combinational burn command for a given (next) phase.
//   phase_i : phase whose control law applies
//   alt_i   : altitude sample (unsigned)
//   velo_i  : velocity sample (signed, negative = descending)
//   fuel_i  : remaining fuel (unsigned)
//   burn_o  : clamp(Gravity + v_tgt - velo, 0, min(BurnMax, fuel)); 0 outside BRAKE/FINAL
module lunar_burn_law
    import lunar_pkg::*;
#(
    parameter int unsigned NBITS_ALT  = NbitsAlt,
    parameter int unsigned NBITS_VELO = NbitsVelo,
    parameter int unsigned NBITS_COMB = NbitsComb,
    parameter int unsigned NBITS_BURN = NbitsBurn
) (
    input  phase_e                       phase_i,
    input  logic [NBITS_ALT-1:0]         alt_i,
    input  logic signed [NBITS_VELO-1:0] velo_i,
    input  logic [NBITS_COMB-1:0]        fuel_i,
    output logic [NBITS_BURN-1:0]        burn_o
);

    // 32-bit arithmetic keeps raw free of wrap for any width of the inputs.
    int unsigned alt_div;
    int          v_tgt;
    int          raw;
    int          cap;
    int          clamped;

    always_comb begin
        alt_div = 32'(alt_i) >> 3;
        v_tgt   = 0;
        raw     = 0;
        cap     = (int'(fuel_i) < BurnMax) ? int'(fuel_i) : BurnMax;
        clamped = 0;
        unique case (phase_i)
            PhBrake: v_tgt = (alt_div > VTgtCap) ? -int'(VTgtCap) : -int'(alt_div);
            PhFinal: v_tgt = VeloFinal;
            default: v_tgt = 0;
        endcase
        raw = Gravity + v_tgt - int'(velo_i);
        if (phase_i == PhBrake || phase_i == PhFinal) begin
            if (raw < 0) begin
                clamped = 0;
            end else if (raw > cap) begin
                clamped = cap;
            end else begin
                clamped = raw;
            end
        end
        burn_o = NBITS_BURN'(clamped);
    end

endmodule

// File: rtl/lunar_autopilot.sv
// lunar_autopilot: tick-driven descent autopilot for the lunar lander.
//   clk_2   : clock, rising edge
//   reset   : asynchronous active-high reset
//   enable  : autopilot engaged
//   tick    : one-cycle strobe marking a new alt/velo/fuel sample
//   alt, velo, fuel : lander sample
//   burn    : registered burn command for the next lander step
//   phase   : current phase encoding (lunar_pkg::phase_e)
//   landed / crashed : sticky touchdown outcome
//   steps   : saturating count of ticks that leave the FSM in an active phase
module lunar_autopilot
    import lunar_pkg::*;
#(
    parameter int unsigned NBITS_ALT  = NbitsAlt,
    parameter int unsigned NBITS_VELO = NbitsVelo,
    parameter int unsigned NBITS_COMB = NbitsComb,
    parameter int unsigned NBITS_BURN = NbitsBurn
) (
    input  logic                         clk_2,
    input  logic                         reset,
    input  logic                         enable,
    input  logic                         tick,
    input  logic [NBITS_ALT-1:0]         alt,
    input  logic signed [NBITS_VELO-1:0] velo,
    input  logic [NBITS_COMB-1:0]        fuel,
    output logic [NBITS_BURN-1:0]        burn,
    output logic [2:0]                   phase,
    output logic                         landed,
    output logic                         crashed,
    output logic [7:0]                   steps
);

    phase_e                  phase_q, phase_d;
    logic [NBITS_BURN-1:0]   burn_q, burn_law;
    logic                    landed_q, crashed_q;
    logic [7:0]              steps_q;
    logic                    touchdown;

    // Burn uses the law of the phase we are about to enter.
    lunar_burn_law #(
        .NBITS_ALT  (NBITS_ALT),
        .NBITS_VELO (NBITS_VELO),
        .NBITS_COMB (NBITS_COMB),
        .NBITS_BURN (NBITS_BURN)
    ) u_burn_law (
        .phase_i (phase_d),
        .alt_i   (alt),
        .velo_i  (velo),
        .fuel_i  (fuel),
        .burn_o  (burn_law)
    );

    // Next phase assuming the current sample is accepted; the register gates on tick.
    always_comb begin
        phase_d   = phase_q;
        touchdown = 1'b0;
        unique case (phase_q)
            PhIdle: begin
                if (enable) phase_d = PhCoast;
            end
            PhCoast, PhBrake, PhFinal: begin
                // Touchdown outranks disengage and every descent transition.
                if (alt == '0) begin
                    phase_d   = PhDone;
                    touchdown = 1'b1;
                end else if (!enable) begin
                    phase_d = PhIdle;
                end else if (phase_q == PhCoast &&
                             (32'(alt) < AltBrake || int'(velo) < VeloBrake)) begin
                    phase_d = PhBrake;
                end else if (phase_q == PhBrake && 32'(alt) < AltFinal) begin
                    phase_d = PhFinal;
                end
            end
            default: phase_d = phase_q;
        endcase
    end

    always_ff @(posedge clk_2 or posedge reset) begin
        if (reset) begin
            phase_q   <= PhIdle;
            burn_q    <= '0;
            landed_q  <= 1'b0;
            crashed_q <= 1'b0;
            steps_q   <= '0;
        end else if (tick) begin
            phase_q <= phase_d;
            burn_q  <= burn_law;
            if (touchdown) begin
                if (int'(velo) >= VeloSafe) landed_q <= 1'b1;
                else                        crashed_q <= 1'b1;
            end
            if (is_active(phase_d) && steps_q != 8'hFF) begin
                steps_q <= steps_q + 8'd1;
            end
        end
    end

    assign burn    = burn_q;
    assign phase   = phase_q;
    assign landed  = landed_q;
    assign crashed = crashed_q;
    assign steps   = steps_q;

endmodule

// File: tb/tb_lunar_autopilot.sv
// tb_lunar_autopilot: scoreboard bench for lunar_autopilot.
// Stimulus drives one cycle per call on the falling edge and pushes the expected
// post-edge outputs from a behavioural lander-autopilot model; a monitor pops and
// compares one entry shortly after each rising edge.
module tb_lunar_autopilot;

    localparam int IDLE  = 0;
    localparam int COAST = 1;
    localparam int BRAKE = 2;
    localparam int FINAL = 3;
    localparam int DONE  = 4;

    typedef struct {
        int ph;
        int burn;
        int landed;
        int crashed;
        int steps;
    } exp_t;

    logic               clk_2 = 1'b0;
    logic               reset = 1'b1;
    logic               enable = 1'b0;
    logic               tick = 1'b0;
    logic [11:0]        alt = '0;
    logic signed [11:0] velo = '0;
    logic [7:0]         fuel = '0;
    logic [6:0]         burn;
    logic [2:0]         phase;
    logic               landed;
    logic               crashed;
    logic [7:0]         steps;

    int errors = 0;
    int checks = 0;
    exp_t sb_q[$];

    // Model state
    int m_ph, m_burn, m_landed, m_crashed, m_steps;

    lunar_autopilot dut (
        .clk_2   (clk_2),
        .reset   (reset),
        .enable  (enable),
        .tick    (tick),
        .alt     (alt),
        .velo    (velo),
        .fuel    (fuel),
        .burn    (burn),
        .phase   (phase),
        .landed  (landed),
        .crashed (crashed),
        .steps   (steps)
    );

    always #5 clk_2 = ~clk_2;

    task automatic chk(input string name, input int act, input int want);
        checks++;
        if (act != want) begin
            errors++;
            $display("FAIL %s: got %0d, want %0d", name, act, want);
        end
    endtask

    task automatic chk_all(input string tag, input exp_t e);
        chk({tag, ".phase"},   int'(phase),   e.ph);
        chk({tag, ".burn"},    int'(burn),    e.burn);
        chk({tag, ".landed"},  int'(landed),  e.landed);
        chk({tag, ".crashed"}, int'(crashed), e.crashed);
        chk({tag, ".steps"},   int'(steps),   e.steps);
    endtask

    function automatic int law(input int ph, input int a, input int v, input int f);
        int vt, raw, cap;
        if (ph == BRAKE)      vt = -(((a / 8) < 40) ? (a / 8) : 40);
        else if (ph == FINAL) vt = -2;
        else                  return 0;
        raw = 5 + vt - v;
        cap = (f < 127) ? f : 127;
        if (raw < 0)   return 0;
        if (raw > cap) return cap;
        return raw;
    endfunction

    function automatic bit is_act(input int ph);
        return ph == COAST || ph == BRAKE || ph == FINAL;
    endfunction

    task automatic model_reset();
        m_ph = IDLE; m_burn = 0; m_landed = 0; m_crashed = 0; m_steps = 0;
    endtask

    task automatic model_tick(input bit en, input int a, input int v, input int f);
        int nxt;
        if (m_ph == DONE) return;
        nxt = m_ph;
        if (!is_act(m_ph)) begin
            if (en) nxt = COAST;
        end else if (a == 0) begin
            nxt = DONE;
            if (v >= -10) m_landed = 1;
            else          m_crashed = 1;
        end else if (!en) begin
            nxt = IDLE;
        end else if (m_ph == COAST && (a < 256 || v < -40)) begin
            nxt = BRAKE;
        end else if (m_ph == BRAKE && a < 64) begin
            nxt = FINAL;
        end
        m_burn = law(nxt, a, v, f);
        if (is_act(nxt) && m_steps < 255) m_steps++;
        m_ph = nxt;
    endtask

    // One clock cycle of stimulus; the expectation covers the outputs after the edge.
    task automatic step(input bit t, input bit en, input int a, input int v, input int f);
        exp_t e;
        @(negedge clk_2);
        tick   = t;
        enable = en;
        alt    = 12'(a);
        velo   = 12'(v);
        fuel   = 8'(f);
        if (t) model_tick(en, a, v, f);
        e.ph = m_ph; e.burn = m_burn; e.landed = m_landed;
        e.crashed = m_crashed; e.steps = m_steps;
        sb_q.push_back(e);
    endtask

    task automatic reset_state_check(input string tag);
        exp_t e;
        e.ph = IDLE; e.burn = 0; e.landed = 0; e.crashed = 0; e.steps = 0;
        chk_all(tag, e);
    endtask

    task automatic do_reset();
        @(negedge clk_2);
        tick  = 1'b0;
        reset = 1'b1;
        #1;
        reset_state_check("rst");
        model_reset();
        @(negedge clk_2);
        reset = 1'b0;
    endtask

    // Monitor: one expected entry per driven cycle.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk_2);
            #1;
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                chk_all("sb", e);
            end
        end
    end

    initial begin
        int a, v, f;
        bit t, en;
        model_reset();
        #1;
        reset_state_check("por");
        @(negedge clk_2);
        reset = 1'b0;

        // Directed descent to a safe landing
        step(1, 1, 500, -30, 120);   // COAST, burn 0, steps 1
        step(0, 1, 300, -30, 120);   // no tick: hold
        step(1, 1, 200, -50, 120);   // BRAKE, burn 30
        step(1, 1, 100, 10, 120);    // BRAKE, raw -17 -> 0
        step(1, 1, 40, -10, 3);      // FINAL, raw 13 -> fuel 3
        step(1, 1, 20, -8, 0);       // FINAL, fuel 0 -> burn 0
        step(1, 1, 0, -4, 120);      // DONE, landed
        step(1, 1, 300, -50, 120);   // ignored
        step(1, 0, 0, -40, 120);     // ignored

        // Asynchronous reset mid-BRAKE
        do_reset();
        step(1, 1, 500, -30, 120);
        step(1, 1, 200, -50, 120);
        step(0, 1, 200, -50, 120);
        @(posedge clk_2);
        #2;
        reset = 1'b1;
        tick  = 1'b0;
        #1;
        chk("async.phase", int'(phase), IDLE);
        chk("async.burn",  int'(burn),  0);
        chk("async.steps", int'(steps), 0);
        model_reset();
        @(negedge clk_2);
        reset = 1'b0;

        // Crash run
        step(1, 1, 500, -30, 120);
        step(1, 1, 200, -50, 120);
        step(1, 1, 40, -10, 120);
        step(1, 1, 0, -20, 120);     // crashed
        step(1, 1, 0, -4, 120);      // ignored
        step(1, 0, 100, -4, 120);    // ignored

        // Disengage from COAST
        do_reset();
        step(1, 1, 500, -30, 120);
        step(1, 0, 480, -30, 120);   // IDLE, steps held at 1
        step(1, 1, 470, -30, 120);   // back to COAST, steps 2

        // Randomised episodes
        for (int ep = 0; ep < 8; ep++) begin
            do_reset();
            for (int i = 0; i < 40; i++) begin
                t  = ($urandom_range(0, 3) != 0);
                en = ($urandom_range(0, 9) != 0);
                a  = ($urandom_range(0, 11) == 0) ? 0 : int'($urandom_range(1, 700));
                v  = int'($urandom_range(0, 300)) - 200;
                f  = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(0, 255));
                step(t, en, a, v, f);
            end
        end

        // Long airborne run to reach the steps saturation point
        do_reset();
        for (int i = 0; i < 270; i++) begin
            a = int'($urandom_range(1, 4000));
            v = int'($urandom_range(0, 200)) - 150;
            f = int'($urandom_range(0, 255));
            step(1, 1, a, v, f);
        end
        step(0, 1, 1000, -20, 100);

        // Drain the scoreboard with a bounded wait
        for (int i = 0; i < 10 && sb_q.size() != 0; i++) @(posedge clk_2);
        #2;
        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending, want 0", sb_q.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
